fp_align_add: RTL and testbench

- Multi-cycle floating-point add/subtract core for the 27-bit format: sign[26], exp[25:18], fraction[17:0], with an explicit leading one at fraction bit 17.
- Swaps the operands by magnitude, right-aligns the smaller operand one bit per cycle, and adds or subtracts the 18-bit fractions.
- Emits the un-normalised result plus a carry flag. This output feeds the shift-normaliser stage directly downstream.
- Uses valid/ready handshakes on both sides and processes one operation at a time.

---
 rtl/fp_align_add_if.sv | 29 ++
 rtl/fp_align_add.sv | 135 +++++++++++++
 tb/tb_fp_align_add.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fp_align_add_if.sv
// Handshake bundle for fp_align_add: operand side and result side.
// No logic; carries operands/op in, un-normalised sum/carry out.
// Valid/ready on both sides; the slave modport is the adder's view.
interface fp_align_add_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 18
);
    localparam int W = 1 + EXP_W + FRAC_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry;

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, sum, carry
    );

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, sum, carry
    );
endinterface

// File: rtl/fp_align_add.sv
// Floating-point add/subtract: magnitude swap, 1-bit/cycle alignment, fraction add/sub.
// Latency: diff+1 edges from accept (1 edge when diff >= FRAC_W), max FRAC_W edges.
// One op in flight; in_ready only in IDLE; result held in DONE until out_ready.
module fp_align_add #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 18
) (
    input logic         clk,
    input logic         rst,
    fp_align_add_if.slave bus
);
    localparam int W     = 1 + EXP_W + FRAC_W;
    localparam int CNT_W = $clog2(FRAC_W + 1);
    localparam logic [EXP_W:0] FRAC_LIM = (EXP_W + 1)'(FRAC_W);

    typedef enum logic [1:0] {IDLE, ALIGN, DONE} state_t;

    state_t              state_q,      state_d;
    logic                big_sign_q,   big_sign_d;
    logic [EXP_W-1:0]    big_exp_q,    big_exp_d;
    logic [FRAC_W-1:0]   big_frac_q,   big_frac_d;
    logic [FRAC_W-1:0]   small_frac_q, small_frac_d;
    logic                sub_q,        sub_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [W-1:0]        sum_q,        sum_d;
    logic                carry_q,      carry_d;

    // Operand decode for the accept edge
    logic                a_sign, b_sign_eff, a_big;
    logic [EXP_W-1:0]    a_exp, b_exp, diff;
    logic [FRAC_W-1:0]   a_frac, b_frac;
    logic [FRAC_W:0]     add_res;
    logic [FRAC_W-1:0]   sub_res;

    assign a_sign     = bus.a[W-1];
    assign b_sign_eff = bus.b[W-1] ^ bus.op;
    assign a_exp      = bus.a[W-2 -: EXP_W];
    assign b_exp      = bus.b[W-2 -: EXP_W];
    assign a_frac     = bus.a[FRAC_W-1:0];
    assign b_frac     = bus.b[FRAC_W-1:0];
    // Unsigned {exp,frac} compare; a tie keeps A as the big operand
    assign a_big      = (bus.a[W-2:0] >= bus.b[W-2:0]);
    assign diff       = a_big ? (a_exp - b_exp) : (b_exp - a_exp);

    assign add_res    = {1'b0, big_frac_q} + {1'b0, small_frac_q};
    assign sub_res    = big_frac_q - small_frac_q;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;

    // Next-state and datapath updates for accept, alignment shift and result
    always_comb begin
        state_d      = state_q;
        big_sign_d   = big_sign_q;
        big_exp_d    = big_exp_q;
        big_frac_d   = big_frac_q;
        small_frac_d = small_frac_q;
        sub_d        = sub_q;
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        carry_d      = carry_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    big_sign_d = a_big ? a_sign : b_sign_eff;
                    big_exp_d  = a_big ? a_exp  : b_exp;
                    big_frac_d = a_big ? a_frac : b_frac;
                    sub_d      = (a_sign != b_sign_eff);
                    // Shifts of FRAC_W or more would clear the fraction anyway
                    if ({1'b0, diff} < FRAC_LIM) begin
                        cnt_d        = diff[CNT_W-1:0];
                        small_frac_d = a_big ? b_frac : a_frac;
                    end else begin
                        cnt_d        = '0;
                        small_frac_d = '0;
                    end
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (cnt_q != '0) begin
                    small_frac_d = small_frac_q >> 1;
                    cnt_d        = cnt_q - 1'b1;
                end else begin
                    if (sub_q) begin
                        carry_d = 1'b0;
                        sum_d   = {big_sign_q, big_exp_q, sub_res};
                    end else begin
                        carry_d = add_res[FRAC_W];
                        sum_d   = {big_sign_q, big_exp_q, add_res[FRAC_W-1:0]};
                    end
                    // Exact zero is reported as positive
                    if (sum_d[FRAC_W-1:0] == '0 && !carry_d) begin
                        sum_d[W-1] = 1'b0;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            big_sign_q   <= 1'b0;
            big_exp_q    <= '0;
            big_frac_q   <= '0;
            small_frac_q <= '0;
            sub_q        <= 1'b0;
            cnt_q        <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            big_sign_q   <= big_sign_d;
            big_exp_q    <= big_exp_d;
            big_frac_q   <= big_frac_d;
            small_frac_q <= small_frac_d;
            sub_q        <= sub_d;
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            carry_q      <= carry_d;
        end
    end
endmodule

// File: tb/tb_fp_align_add.sv
// Directed bench for fp_align_add with hand-computed sums, carries and latencies.
// Covers add, swap/subtract, cancellation, alignment boundaries, backpressure, reset.
// Inputs driven on the falling edge, outputs sampled 1ns after the rising edge.
module tb_fp_align_add;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    fp_align_add_if #(.EXP_W(8), .FRAC_W(18)) bus ();

    fp_align_add #(.EXP_W(8), .FRAC_W(18)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [26:0] mk(input logic s, input logic [7:0] e, input logic [17:0] f);
        return {s, e, f};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op, measure latency, optionally hold out_ready low, then drain.
    task automatic run_op(input string tag, input logic [26:0] a, input logic [26:0] b,
                          input logic op, input logic [26:0] exp_sum,
                          input logic exp_carry, input int exp_lat, input int hold);
        int lat;
        logic [26:0] held_sum;
        logic held_carry;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.a = a; bus.b = b; bus.op = op; bus.in_valid = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1 lat++;
            if (bus.out_valid) break;
        end
        check({tag, "_lat"},   32'(lat),       32'(exp_lat));
        check({tag, "_sum"},   32'(bus.sum),   32'(exp_sum));
        check({tag, "_carry"}, 32'(bus.carry), 32'(exp_carry));
        held_sum   = bus.sum;
        held_carry = bus.carry;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_vld"},   32'(bus.out_valid), 32'd1);
            check({tag, "_hold_rdy"},   32'(bus.in_ready),  32'd0);
            check({tag, "_hold_sum"},   32'(bus.sum),       32'(exp_sum));
            check({tag, "_hold_carry"}, 32'(bus.carry),     32'(exp_carry));
        end
        if (held_sum !== exp_sum || held_carry !== exp_carry) begin
            check({tag, "_latched"}, 32'(held_sum), 32'(exp_sum));
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_drain_vld"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_drain_rdy"}, 32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        int seen;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum",       32'(bus.sum),       32'd0);
        check("rst_carry",     32'(bus.carry),     32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("eq_add",  mk(0,130,18'h20000), mk(0,130,18'h20000), 1'b0, mk(0,130,18'h00000), 1'b1, 1, 0);
        run_op("aln_add", mk(0,130,18'h20000), mk(0,127,18'h20000), 1'b0, mk(0,130,18'h24000), 1'b0, 4, 0);
        run_op("swp_sub", mk(0,127,18'h20000), mk(0,130,18'h30000), 1'b1, mk(1,130,18'h2C000), 1'b0, 4, 0);
        run_op("cancel",  mk(1,130,18'h25000), mk(1,130,18'h25000), 1'b1, mk(0,130,18'h00000), 1'b0, 1, 0);
        run_op("big_diff",mk(0,150,18'h2ABCD), mk(0,100,18'h3FFFF), 1'b0, mk(0,150,18'h2ABCD), 1'b0, 1, 0);
        // diff 17: small shifted down to 1, sum overflows into carry
        run_op("diff17",  mk(0,147,18'h3FFFF), mk(0,130,18'h20000), 1'b0, mk(0,147,18'h00000), 1'b1, 18, 0);
        // diff 18: small dropped entirely
        run_op("diff18",  mk(0,147,18'h3FFFF), mk(0,129,18'h20000), 1'b0, mk(0,147,18'h3FFFF), 1'b0, 1, 0);
        // negative A plus smaller positive B -> negative difference
        run_op("neg_add", mk(1,130,18'h20000), mk(0,130,18'h10000), 1'b0, mk(1,130,18'h10000), 1'b0, 1, 0);
        // held result under backpressure
        run_op("bp",      mk(0,130,18'h20000), mk(0,127,18'h20000), 1'b0, mk(0,130,18'h24000), 1'b0, 4, 5);

        // Reset in the middle of a diff=10 alignment
        @(negedge clk);
        bus.a = mk(0,140,18'h20000); bus.b = mk(0,130,18'h20000); bus.op = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_vld", 32'(bus.out_valid), 32'd0);
        check("mid_rst_rdy", 32'(bus.in_ready),  32'd1);
        check("mid_rst_sum", 32'(bus.sum),       32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1 if (bus.out_valid) seen++;
        end
        check("mid_rst_no_out", 32'(seen), 32'd0);

        run_op("post_rst", mk(0,140,18'h20000), mk(0,130,18'h20000), 1'b0, mk(0,140,18'h20080), 1'b0, 11, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
